// File: rtl/rob_early_recovery_pkg.sv
// rtl/rob_early_recovery_pkg.sv - shared entry types and width defaults for the reorder buffer
//
// Types: rob_disp_entry_t (dispatch payload), rob_ct_entry_t (commit payload),
// rob_entry_t (stored entry with valid/executed state).
package rob_early_recovery_pkg;

   localparam int N_WAY            = 2;
   localparam int FU_ROB_PACKET_SZ = 2;
   localparam int PRN_W            = 6;
   localparam int ARN_W            = 5;

   typedef struct packed {
      logic [31:0]      pc;
      logic [31:0]      npc;
      logic [PRN_W-1:0] dest_prn;
      logic [ARN_W-1:0] dest_arn;
      logic             is_store;
      logic             is_branch;
      logic             predict_taken;
      logic [31:0]      predict_target;
      logic             halt;
      logic             illegal;
   } rob_disp_entry_t;

   typedef struct packed {
      rob_disp_entry_t inst;
      logic            taken;
      logic [31:0]     target;
      logic            mispredict;
   } rob_ct_entry_t;

   typedef struct packed {
      logic          valid;
      logic          executed;
      rob_ct_entry_t data;
   } rob_entry_t;

   // Entries that end the commit scan and freeze the machine.
   function automatic logic stops_commit(input rob_disp_entry_t e);
      return e.halt | e.illegal;
   endfunction

endpackage

// File: rtl/rob_oldest_select.sv
// rtl/rob_oldest_select.sv - picks the oldest requesting index relative to a circular head
//
// Ports:
//   req     - one bit per request lane
//   idx     - circular buffer index carried by each lane
//   head    - current head index; age = (idx - head) mod 2**IDX_W
//   grant   - one-hot lane of the oldest request (lowest lane on ties)
//   win_idx - index of the granted lane
//   any     - at least one lane requested
module rob_oldest_select
   import rob_early_recovery_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]            req,
   input  logic [N-1:0][IDX_W-1:0] idx,
   input  logic [IDX_W-1:0]        head,
   output logic [N-1:0]            grant,
   output logic [IDX_W-1:0]        win_idx,
   output logic                    any
);

   logic [IDX_W-1:0] best_age;
   logic [IDX_W-1:0] lane_age;

   always_comb begin
      grant    = '0;
      win_idx  = '0;
      any      = 1'b0;
      best_age = '0;
      lane_age = '0;
      for (int i = 0; i < N; i++) begin
         lane_age = idx[i] - head;
         // Strict compare keeps the lower lane when two lanes hit the same entry.
         if (req[i] && (!any || lane_age < best_age)) begin
            grant    = '0;
            grant[i] = 1'b1;
            win_idx  = idx[i];
            best_age = lane_age;
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rob_early_recovery.sv
// rtl/rob_early_recovery.sv - reorder buffer with resolve-time branch recovery
//
// Ports:
//   clock, reset                 - rising-edge clock, synchronous active-high reset
//   disp_valid/disp_entry        - contiguous dispatch lanes; disp_robn gives each lane's entry
//   disp_stall, free_cnt         - free < ALERT_DEPTH, and DEPTH - count
//   cdb_valid/robn/taken/target  - writeback lanes marking entries executed
//   ct_valid/ct_entry            - contiguous commit lanes from head; ct_store_cnt stores among them
//   squash/squash_robn/squash_pc - one-cycle redirect after a mispredicted branch resolves
//   halted                       - sticky once a halt or illegal entry commits
module rob_early_recovery
   import rob_early_recovery_pkg::*;
#(
   parameter int DEPTH       = 32,
   parameter int DISP_W      = N_WAY,
   parameter int COMMIT_W    = N_WAY,
   parameter int CDB_W       = FU_ROB_PACKET_SZ,
   parameter int ALERT_DEPTH = DISP_W,
   parameter int ROB_IDX_W   = $clog2(DEPTH),
   parameter int ROB_CNT_W   = ROB_IDX_W + 1,
   parameter int SQ_CNT_W    = $clog2(COMMIT_W + 1)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [DISP_W-1:0]                disp_valid,
   input  rob_disp_entry_t [DISP_W-1:0]     disp_entry,
   output logic [DISP_W-1:0][ROB_IDX_W-1:0] disp_robn,
   output logic                             disp_stall,
   output logic [ROB_CNT_W-1:0]             free_cnt,
   input  logic [CDB_W-1:0]                 cdb_valid,
   input  logic [CDB_W-1:0][ROB_IDX_W-1:0]  cdb_robn,
   input  logic [CDB_W-1:0]                 cdb_taken,
   input  logic [CDB_W-1:0][31:0]           cdb_target,
   output logic [COMMIT_W-1:0]              ct_valid,
   output rob_ct_entry_t [COMMIT_W-1:0]     ct_entry,
   output logic [SQ_CNT_W-1:0]              ct_store_cnt,
   output logic                             squash,
   output logic [ROB_IDX_W-1:0]             squash_robn,
   output logic [31:0]                      squash_pc,
   output logic                             halted
);

   rob_entry_t              rob_q [DEPTH];
   logic [ROB_CNT_W-1:0]    head_q, tail_q, head_next;
   logic [ROB_CNT_W-1:0]    count_q, n_disp, n_commit;
   logic                    disp_take, commit_stop, scan_go;
   logic [ROB_IDX_W-1:0]    scan_idx;
   logic [CDB_W-1:0]        cdb_hit, cdb_mp, cdb_keep, win_grant;
   logic [CDB_W-1:0][31:0]  cdb_res;
   logic                    recover;
   logic [ROB_IDX_W-1:0]    win_idx, win_age, post_age;
   logic [31:0]             win_pc;

   assign free_cnt   = ROB_CNT_W'(DEPTH) - count_q;
   assign disp_stall = free_cnt < ROB_CNT_W'(ALERT_DEPTH);
   assign disp_take  = !disp_stall && !squash && !recover;

   always_comb begin
      n_disp = '0;
      for (int i = 0; i < DISP_W; i++) begin
         disp_robn[i] = tail_q[ROB_IDX_W-1:0] + ROB_IDX_W'(i);
         if (disp_valid[i]) n_disp = n_disp + ROB_CNT_W'(1);
      end
   end

   // Resolved target is the fall-through when not taken, so a not-taken
   // prediction is checked against NPC through predict_target.
   always_comb begin
      cdb_hit = '0;
      cdb_mp  = '0;
      cdb_res = '0;
      for (int j = 0; j < CDB_W; j++) begin
         cdb_hit[j] = cdb_valid[j] && rob_q[cdb_robn[j]].valid;
         cdb_res[j] = cdb_taken[j] ? cdb_target[j] : rob_q[cdb_robn[j]].data.inst.npc;
         cdb_mp[j]  = cdb_hit[j] && rob_q[cdb_robn[j]].data.inst.is_branch &&
                      ((cdb_taken[j] != rob_q[cdb_robn[j]].data.inst.predict_taken) ||
                       (cdb_res[j] != rob_q[cdb_robn[j]].data.inst.predict_target));
      end
   end

   rob_oldest_select #(.N(CDB_W), .IDX_W(ROB_IDX_W)) u_oldest_select (
      .req     (cdb_mp),
      .idx     (cdb_robn),
      .head    (head_q[ROB_IDX_W-1:0]),
      .grant   (win_grant),
      .win_idx (win_idx),
      .any     (recover)
   );

   always_comb begin
      win_pc = '0;
      for (int j = 0; j < CDB_W; j++) begin
         if (win_grant[j]) win_pc = cdb_res[j];
      end
   end

   assign win_age = win_idx - head_q[ROB_IDX_W-1:0];

   // Writebacks to entries younger than this cycle's winner are about to be truncated.
   always_comb begin
      cdb_keep = '0;
      for (int j = 0; j < CDB_W; j++) begin
         cdb_keep[j] = cdb_hit[j] &&
                       !(recover && ((cdb_robn[j] - head_q[ROB_IDX_W-1:0]) > win_age));
      end
   end

   always_comb begin
      ct_valid     = '0;
      ct_entry     = '0;
      ct_store_cnt = '0;
      n_commit     = '0;
      commit_stop  = 1'b0;
      scan_go      = !halted;
      scan_idx     = '0;
      for (int i = 0; i < COMMIT_W; i++) begin
         scan_idx = head_q[ROB_IDX_W-1:0] + ROB_IDX_W'(i);
         if (scan_go && rob_q[scan_idx].valid && rob_q[scan_idx].executed) begin
            ct_valid[i] = 1'b1;
            ct_entry[i] = rob_q[scan_idx].data;
            n_commit    = n_commit + ROB_CNT_W'(1);
            if (rob_q[scan_idx].data.inst.is_store) ct_store_cnt = ct_store_cnt + SQ_CNT_W'(1);
            if (stops_commit(rob_q[scan_idx].data.inst)) begin
               commit_stop = 1'b1;
               scan_go     = 1'b0;
            end
         end else begin
            scan_go = 1'b0;
         end
      end
   end

   // The winner is never committing this cycle, so its age from the post-commit
   // head gives both the surviving count and the new tail with its wrap bit.
   assign head_next = head_q + n_commit;
   assign post_age  = win_idx - head_next[ROB_IDX_W-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) rob_q[k] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         squash      <= 1'b0;
         squash_robn <= '0;
         squash_pc   <= '0;
         halted      <= 1'b0;
      end else begin
         for (int i = 0; i < COMMIT_W; i++) begin
            if (ct_valid[i]) rob_q[head_q[ROB_IDX_W-1:0] + ROB_IDX_W'(i)].valid <= 1'b0;
         end
         for (int j = 0; j < CDB_W; j++) begin
            if (cdb_keep[j]) begin
               rob_q[cdb_robn[j]].executed        <= 1'b1;
               rob_q[cdb_robn[j]].data.taken      <= cdb_taken[j];
               rob_q[cdb_robn[j]].data.target     <= cdb_res[j];
               rob_q[cdb_robn[j]].data.mispredict <= cdb_mp[j];
            end
         end
         if (recover) begin
            for (int k = 0; k < DEPTH; k++) begin
               if ((ROB_IDX_W'(k) - head_q[ROB_IDX_W-1:0]) > win_age) rob_q[k].valid <= 1'b0;
            end
         end
         if (disp_take) begin
            for (int i = 0; i < DISP_W; i++) begin
               if (disp_valid[i]) begin
                  rob_q[disp_robn[i]].valid           <= 1'b1;
                  rob_q[disp_robn[i]].executed        <= 1'b0;
                  rob_q[disp_robn[i]].data.inst       <= disp_entry[i];
                  rob_q[disp_robn[i]].data.taken      <= 1'b0;
                  rob_q[disp_robn[i]].data.target     <= '0;
                  rob_q[disp_robn[i]].data.mispredict <= 1'b0;
               end
            end
         end

         head_q <= head_next;
         if (recover) begin
            tail_q  <= head_next + ROB_CNT_W'(post_age) + ROB_CNT_W'(1);
            count_q <= ROB_CNT_W'(post_age) + ROB_CNT_W'(1);
         end else if (disp_take) begin
            tail_q  <= tail_q + n_disp;
            count_q <= count_q + n_disp - n_commit;
         end else begin
            count_q <= count_q - n_commit;
         end

         squash <= recover;
         if (recover) begin
            squash_robn <= win_idx;
            squash_pc   <= win_pc;
         end
         if (commit_stop) halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rob_early_recovery.sv
// tb/tb_rob_early_recovery.sv - directed bench with commit-order scoreboard for rob_early_recovery
module tb_rob_early_recovery;
   import rob_early_recovery_pkg::*;

   logic                  clock;
   logic                  reset;
   logic [1:0]            disp_valid;
   rob_disp_entry_t [1:0] disp_entry;
   logic [1:0][2:0]       disp_robn;
   logic                  disp_stall;
   logic [3:0]            free_cnt;
   logic [1:0]            cdb_valid;
   logic [1:0][2:0]       cdb_robn;
   logic [1:0]            cdb_taken;
   logic [1:0][31:0]      cdb_target;
   logic [3:0]            ct_valid;
   rob_ct_entry_t [3:0]   ct_entry;
   logic [2:0]            ct_store_cnt;
   logic                  squash;
   logic [2:0]            squash_robn;
   logic [31:0]           squash_pc;
   logic                  halted;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_want;

   rob_early_recovery #(
      .DEPTH(8), .DISP_W(2), .COMMIT_W(4), .CDB_W(2), .ALERT_DEPTH(2)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .disp_valid   (disp_valid),
      .disp_entry   (disp_entry),
      .disp_robn    (disp_robn),
      .disp_stall   (disp_stall),
      .free_cnt     (free_cnt),
      .cdb_valid    (cdb_valid),
      .cdb_robn     (cdb_robn),
      .cdb_taken    (cdb_taken),
      .cdb_target   (cdb_target),
      .ct_valid     (ct_valid),
      .ct_entry     (ct_entry),
      .ct_store_cnt (ct_store_cnt),
      .squash       (squash),
      .squash_robn  (squash_robn),
      .squash_pc    (squash_pc),
      .halted       (halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic rob_disp_entry_t mk(input logic [31:0] pc, input logic br,
                                          input logic st, input logic hl);
      rob_disp_entry_t e;
      e                = '0;
      e.pc             = pc;
      e.npc            = pc + 32'd4;
      e.predict_target = pc + 32'd4;
      e.dest_arn       = pc[6:2];
      e.dest_prn       = pc[7:2];
      e.is_branch      = br;
      e.is_store       = st;
      e.halt           = hl;
      return e;
   endfunction

   task automatic disp2(input rob_disp_entry_t a, input rob_disp_entry_t b, input logic [1:0] v);
      disp_valid    = v;
      disp_entry[0] = a;
      disp_entry[1] = b;
      if (v[0]) exp_q.push_back(a.pc);
      if (v[1]) exp_q.push_back(b.pc);
      tick();
      disp_valid = '0;
   endtask

   task automatic cdb(input logic [1:0] v, input logic [2:0] r0, input logic t0, input logic [31:0] g0,
                      input logic [2:0] r1, input logic t1, input logic [31:0] g1);
      cdb_valid     = v;
      cdb_robn[0]   = r0;
      cdb_taken[0]  = t0;
      cdb_target[0] = g0;
      cdb_robn[1]   = r1;
      cdb_taken[1]  = t1;
      cdb_target[1] = g1;
      tick();
      cdb_valid = '0;
   endtask

   task automatic trunc(input int n);
      repeat (n) void'(exp_q.pop_back());
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      disp_valid = '0;
      cdb_valid  = '0;
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   // Scoreboard: every committing lane must match the oldest surviving dispatched PC.
   always @(negedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            if (ct_valid[i]) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $error("FAIL sb_underflow observed_pc=0x%0h expected=none", ct_entry[i].inst.pc);
               end else begin
                  mon_want = exp_q.pop_front();
                  chk("commit_pc", 64'(ct_entry[i].inst.pc), 64'(mon_want));
               end
            end
         end
         if (|disp_valid) begin
            n_cmp++;
            assert (!disp_stall) else begin
               n_bad++;
               $error("FAIL disp_while_stall observed=1 expected=0");
            end
         end
      end
   end

   initial begin
      reset      = 1'b1;
      disp_valid = '0;
      disp_entry = '0;
      cdb_valid  = '0;
      cdb_robn   = '0;
      cdb_taken  = '0;
      cdb_target = '0;
      do_reset();

      // Reset state and fill
      chk("rst_free", 64'(free_cnt), 8);
      chk("rst_stall", 64'(disp_stall), 0);
      chk("rst_ct_valid", 64'(ct_valid), 0);
      chk("rst_store_cnt", 64'(ct_store_cnt), 0);
      chk("rst_squash", 64'(squash), 0);
      chk("rst_squash_robn", 64'(squash_robn), 0);
      chk("rst_squash_pc", 64'(squash_pc), 0);
      chk("rst_halted", 64'(halted), 0);
      chk("robn_c1_l0", 64'(disp_robn[0]), 0);
      chk("robn_c1_l1", 64'(disp_robn[1]), 1);
      disp2(mk(32'h1000, 0, 0, 0), mk(32'h1004, 0, 0, 0), 2'b11);
      chk("robn_c2_l0", 64'(disp_robn[0]), 2);
      chk("robn_c2_l1", 64'(disp_robn[1]), 3);
      disp2(mk(32'h1008, 0, 0, 0), mk(32'h100c, 0, 0, 0), 2'b11);
      chk("robn_c3_l0", 64'(disp_robn[0]), 4);
      chk("robn_c3_l1", 64'(disp_robn[1]), 5);
      disp2(mk(32'h1010, 0, 0, 0), mk(32'h1014, 0, 0, 0), 2'b11);
      chk("free_after3", 64'(free_cnt), 2);
      chk("stall_at6", 64'(disp_stall), 0);
      chk("robn_c4_l0", 64'(disp_robn[0]), 6);
      disp2(mk(32'h1018, 0, 0, 0), mk(32'h101c, 0, 0, 0), 2'b01);
      chk("free_at7", 64'(free_cnt), 1);
      chk("stall_at7", 64'(disp_stall), 1);

      // Out-of-order completion: 1 then 0
      cdb(2'b01, 3'd1, 0, 0, 0, 0, 0);
      chk("ooo_no_commit", 64'(ct_valid), 0);
      cdb(2'b01, 3'd0, 0, 0, 0, 0, 0);
      chk("ooo_commit_pair", 64'(ct_valid), 64'b0011);
      tick();
      chk("ooo_after_ct", 64'(ct_valid), 0);
      chk("ooo_free", 64'(free_cnt), 3);
      chk("ooo_stall", 64'(disp_stall), 0);

      // Single mispredict at robn 2 with same-cycle dispatch
      do_reset();
      disp2(mk(32'h2000, 0, 0, 0), mk(32'h2004, 0, 1, 0), 2'b11);
      disp2(mk(32'h2008, 1, 0, 0), mk(32'h200c, 0, 0, 0), 2'b11);
      disp2(mk(32'h2010, 0, 0, 0), mk(32'h2014, 0, 0, 0), 2'b11);
      disp_valid    = 2'b11;
      disp_entry[0] = mk(32'h2100, 0, 0, 0);
      disp_entry[1] = mk(32'h2104, 0, 0, 0);
      cdb_valid     = 2'b01;
      cdb_robn[0]   = 3'd2;
      cdb_taken[0]  = 1'b1;
      cdb_target[0] = 32'h100;
      tick();
      disp_valid = '0;
      cdb_valid  = '0;
      trunc(3);
      chk("mp_squash", 64'(squash), 1);
      chk("mp_squash_robn", 64'(squash_robn), 2);
      chk("mp_squash_pc", 64'(squash_pc), 32'h100);
      chk("mp_free", 64'(free_cnt), 5);
      chk("mp_tail", 64'(disp_robn[0]), 3);
      tick();
      chk("mp_squash_pulse", 64'(squash), 0);
      chk("mp_tail_hold", 64'(disp_robn[0]), 3);
      disp2(mk(32'h2200, 0, 0, 0), mk(32'h2204, 0, 0, 0), 2'b11);
      cdb(2'b11, 3'd0, 0, 0, 3'd1, 0, 0);
      chk("mp_ct_valid", 64'(ct_valid), 64'b0111);
      chk("mp_store_cnt", 64'(ct_store_cnt), 1);
      chk("mp_ct_mispredict", 64'(ct_entry[2].mispredict), 1);
      chk("mp_ct_taken", 64'(ct_entry[2].taken), 1);
      chk("mp_ct_target", 64'(ct_entry[2].target), 32'h100);
      cdb(2'b11, 3'd3, 0, 0, 3'd4, 0, 0);
      chk("mp_ct_valid2", 64'(ct_valid), 64'b0011);
      chk("mp_store_cnt2", 64'(ct_store_cnt), 0);
      tick();
      chk("mp_drain_free", 64'(free_cnt), 8);

      // Two mispredicts in one cycle: robn 4 and robn 1
      do_reset();
      disp2(mk(32'h3000, 0, 0, 0), mk(32'h3004, 1, 0, 0), 2'b11);
      disp2(mk(32'h3008, 0, 0, 0), mk(32'h300c, 0, 0, 0), 2'b11);
      disp2(mk(32'h3010, 1, 0, 0), mk(32'h3014, 0, 0, 0), 2'b11);
      cdb(2'b11, 3'd4, 1, 32'h200, 3'd1, 1, 32'h300);
      trunc(4);
      chk("mp2_squash", 64'(squash), 1);
      chk("mp2_robn", 64'(squash_robn), 1);
      chk("mp2_pc", 64'(squash_pc), 32'h300);
      chk("mp2_free", 64'(free_cnt), 6);
      chk("mp2_tail", 64'(disp_robn[0]), 2);
      cdb(2'b01, 3'd4, 1, 32'h500, 0, 0, 0);
      chk("mp2_truncated_ignored", 64'(squash), 0);
      chk("mp2_free_hold", 64'(free_cnt), 6);
      cdb(2'b01, 3'd0, 0, 0, 0, 0, 0);
      chk("mp2_ct_valid", 64'(ct_valid), 64'b0011);
      chk("mp2_ct_mispredict", 64'(ct_entry[1].mispredict), 1);
      tick();
      chk("mp2_drain_free", 64'(free_cnt), 8);

      // Wrap-around: head=6, tail wrapped to 2, mispredict at robn 7
      do_reset();
      disp2(mk(32'h4000, 0, 0, 0), mk(32'h4004, 0, 0, 0), 2'b11);
      disp2(mk(32'h4008, 0, 0, 0), mk(32'h400c, 0, 0, 0), 2'b11);
      disp2(mk(32'h4010, 0, 0, 0), mk(32'h4014, 0, 0, 0), 2'b11);
      cdb(2'b11, 3'd0, 0, 0, 3'd1, 0, 0);
      cdb(2'b11, 3'd2, 0, 0, 3'd3, 0, 0);
      cdb(2'b11, 3'd4, 0, 0, 3'd5, 0, 0);
      tick();
      chk("wrap_empty_free", 64'(free_cnt), 8);
      chk("wrap_tail6", 64'(disp_robn[0]), 6);
      disp2(mk(32'h4018, 0, 0, 0), mk(32'h401c, 1, 0, 0), 2'b11);
      chk("wrap_tail0", 64'(disp_robn[0]), 0);
      disp2(mk(32'h4020, 0, 0, 0), mk(32'h4024, 0, 0, 0), 2'b11);
      chk("wrap_free4", 64'(free_cnt), 4);
      cdb(2'b01, 3'd7, 1, 32'h400, 0, 0, 0);
      trunc(2);
      chk("wrap_robn", 64'(squash_robn), 7);
      chk("wrap_pc", 64'(squash_pc), 32'h400);
      chk("wrap_free", 64'(free_cnt), 6);
      chk("wrap_tail", 64'(disp_robn[0]), 0);
      cdb(2'b01, 3'd6, 0, 0, 0, 0, 0);
      chk("wrap_ct_valid", 64'(ct_valid), 64'b0011);
      tick();
      chk("wrap_drain_free", 64'(free_cnt), 8);
      chk("wrap_tail_after", 64'(disp_robn[0]), 0);
      disp2(mk(32'h4030, 0, 0, 0), mk(32'h4034, 0, 0, 0), 2'b11);
      chk("wrap_redisp_free", 64'(free_cnt), 6);

      // Halt at robn 3 behind executed 0..2
      do_reset();
      disp2(mk(32'h5000, 0, 0, 0), mk(32'h5004, 0, 0, 0), 2'b11);
      disp2(mk(32'h5008, 0, 0, 0), mk(32'h500c, 0, 0, 1), 2'b11);
      disp2(mk(32'h5010, 0, 0, 0), mk(32'h5014, 0, 0, 0), 2'b11);
      cdb(2'b11, 3'd1, 0, 0, 3'd2, 0, 0);
      chk("halt_wait1", 64'(ct_valid), 0);
      cdb(2'b11, 3'd3, 0, 0, 3'd4, 0, 0);
      chk("halt_wait2", 64'(ct_valid), 0);
      cdb(2'b01, 3'd0, 0, 0, 0, 0, 0);
      chk("halt_ct_valid", 64'(ct_valid), 64'b1111);
      chk("halt_not_yet", 64'(halted), 0);
      tick();
      chk("halt_set", 64'(halted), 1);
      chk("halt_no_commit", 64'(ct_valid), 0);
      tick();
      chk("halt_no_commit2", 64'(ct_valid), 0);
      chk("halt_free", 64'(free_cnt), 6);

      // Reset mid-operation with live inputs
      reset         = 1'b1;
      disp_valid    = 2'b11;
      disp_entry[0] = mk(32'h6000, 0, 0, 0);
      disp_entry[1] = mk(32'h6004, 0, 0, 0);
      cdb_valid     = 2'b01;
      cdb_robn[0]   = 3'd4;
      cdb_taken[0]  = 1'b0;
      tick();
      reset      = 1'b0;
      disp_valid = '0;
      cdb_valid  = '0;
      exp_q.delete();
      chk("rst2_halted", 64'(halted), 0);
      chk("rst2_free", 64'(free_cnt), 8);
      chk("rst2_ct_valid", 64'(ct_valid), 0);
      chk("rst2_squash", 64'(squash), 0);
      chk("rst2_tail", 64'(disp_robn[0]), 0);
      tick();
      chk("rst2_idle_ct", 64'(ct_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rob_early_recovery.md
Name: rob_early_recovery

Overview:
- Parametrised reorder buffer for the out-of-order core. Sits between dispatch, the CDB/FU writeback, the store queue and the architectural map/free list.
- Dispatch, commit and CDB widths are independent parameters.
- Mispredicted branches recover at resolve time: only younger entries are truncated and a redirect is issued. There is no full flush at commit.
- Illegal and halt instructions stop commit precisely.

Parameters:
- DEPTH, 32, number of entries; power of two, >= 2*DISP_W.
- DISP_W, `N, dispatch lanes per cycle.
- COMMIT_W, `N, maximum commits per cycle.
- CDB_W, `FU_ROB_PACKET_SZ, writeback ports per cycle.
- ALERT_DEPTH, DISP_W, disp_stall asserts when free entries < ALERT_DEPTH.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- disp_valid, input, DISP_W, lane valid; set lanes are contiguous from lane 0.
- disp_entry, input, DISP_W x ROB_DISP_ENTRY, PC, NPC, dest_prn, dest_arn, is_store, is_branch, predict_taken, predict_target, halt, illegal.
- disp_robn, output, DISP_W x ROB_IDX_W, index allocated to each lane; equals (tail+i) mod DEPTH.
- disp_stall, output, 1, free < ALERT_DEPTH.
- free_cnt, output, ROB_CNT_W, DEPTH − count.
- cdb_valid, input, CDB_W, writeback valid.
- cdb_robn, input, CDB_W x ROB_IDX_W, target entry.
- cdb_taken, input, CDB_W, resolved direction.
- cdb_target, input, CDB_W x 32, resolved target when taken.
- ct_valid, output, COMMIT_W, lanes committing this cycle; contiguous from lane 0.
- ct_entry, output, COMMIT_W x ROB_CT_ENTRY, committing entry contents.
- ct_store_cnt, output, SQ_CNT_W, number of stores in ct_valid lanes.
- squash, output, 1, registered recovery pulse.
- squash_robn, output, ROB_IDX_W, mispredicted branch index.
- squash_pc, output, 32, redirect PC.
- halted, output, 1, sticky; a halt or illegal entry has committed.

Behaviour:
- Reset: head=tail=0, count=0, all entry valid/executed=0. Outputs: ct_valid=0, ct_store_cnt=0, squash=0, squash_robn=0, squash_pc=0, halted=0, free_cnt=DEPTH, disp_stall=0.
- Pointers: head and tail carry a wrap bit (ROB_IDX_W+1 bits); full/empty are decided by the wrap bit. Age(x) = (x − head) mod DEPTH.
- Dispatch:
  - Accepted when disp_stall=0 and squash=0. Otherwise lanes are dropped; the front end must hold them.
  - Accepted lanes write entry (tail+i) with valid=1, executed=0, mispredict=0.
  - tail and count advance by popcount(disp_valid); entries are visible next cycle.
  - Dispatch with disp_stall=1 is a protocol error: assertion in the bench, ignored in RTL.
- CDB:
  - Sets executed; records resolved taken/target; target = cdb_target if taken, else NPC.
  - For is_branch: mispredict = (taken != predict_taken) or (target != predict_target).
  - Writes to an invalid entry, or to an entry being truncated this cycle, are ignored.
  - Stores are marked executed by the CDB on address/data ready.
- Recovery:
  - Among this cycle's mispredicting CDB lanes, the oldest by Age wins.
  - At the next edge: tail = winner+1 (wrap bit recomputed from Age), count = Age(winner)+1, younger entries valid=0.
  - Same-cycle dispatch is discarded.
  - squash=1 for exactly that next cycle, with squash_robn=winner and squash_pc=resolved target.
  - A mispredict older than a squash already in flight wins the next cycle normally. A younger one was truncated and is ignored.
- Commit (reads registered state only):
  - Lanes 0..COMMIT_W-1 scan from head; stop at the first entry that is invalid or not executed.
  - A halt/illegal entry commits in its lane, stops the scan, and sets halted at the next edge.
  - With halted=1, no further commits occur until reset.
  - head and count decrease by the number of commits. The mispredicted branch itself commits normally.
- Simultaneous events:
  - Count update = count + dispatched − committed, or the recovery value when recovering.
  - Recovery count is computed relative to the post-commit head.
  - Commit and truncate never overlap: truncated entries are strictly younger than an unexecuted-or-just-executed branch.
- Reset mid-operation: all state returns to reset values at the edge; in-flight CDB and dispatch inputs are dropped.

Decomposition:
- Shared package (sys_defs.svh): ROB_DISP_ENTRY, ROB_CT_ENTRY, ROB_ENTRY structs; ROB_IDX_W = $clog2(DEPTH); ROB_CNT_W = ROB_IDX_W+1.
- Sub-module rob_oldest_select: CDB_W mispredict requests plus head → one-hot oldest winner and index. Pure combinational, reusable by the LSQ.

Test Plan:
- Reset, DEPTH=8, DISP_W=2: dispatch 2 per cycle for 4 cycles → disp_robn 0,1/2,3/4,5; disp_stall=1 from count=7; free_cnt=2 after cycle 3.
- Out-of-order completion: CDB completes robn 1, then robn 0 → commit of 0 and 1 in the same cycle only after robn 0 completes; ct_valid=2'b11.
- Mispredict: entries 0..5 valid; CDB robn 2 predict_taken=0, cdb_taken=1, target 0x100 → next cycle squash=1, squash_robn=2, squash_pc=0x100, tail=3, free_cnt=5; same-cycle dispatch dropped.
- Two mispredicts in one cycle, robn 4 and robn 1, head=0 → only robn 1 wins, tail=2.
- Wrap-around: head=6, tail wrapped to 2, mispredict at robn 7 → tail=0 with wrap bit set; count=2.
- Halt at robn 3 behind executed 0..2, COMMIT_W=4 → ct_valid=4'b1111, halted=1 next cycle, no commits afterwards.
